dram_arbiter: RTL and testbench

- Two-master AHB-lite arbiter that shares the byte-lane data RAM between the vscale core data port (dmem_*) and the SPI loader (spi_*).
- Captures each master's address phase into a one-entry pending buffer, schedules pending entries round-robin with lock support, and drives the RAM word address, read/write-not, and byte write enables.
- Checks alignment and size, and returns a two-cycle AHB ERROR response without touching the RAM.

---
 rtl/dram_arbiter_pkg.sv | 40 ++++
 rtl/dram_arbiter_port.sv | 92 +++++++++
 rtl/dram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared AHB-lite encodings and byte-lane helpers for the DRAM arbiter.
package dram_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte write enables for a transfer of the given size at the given byte offset.
  function automatic logic [3:0] wben_f(input logic [2:0] size, input logic [1:0] ofs);
    logic [3:0] en;
    case (size)
      HSIZE_BYTE: en = 4'b0001 << ofs;
      HSIZE_HALF: en = 4'b0011 << {ofs[1], 1'b0};
      default:    en = 4'b1111;
    endcase
    return en;
  endfunction

  // Oversized or misaligned transfers are answered with ERROR.
  function automatic logic size_err_f(input logic [2:0] size, input logic [1:0] ofs);
    logic err;
    err = 1'b0;
    if (size > HSIZE_WORD)
      err = 1'b1;
    else if ((size == HSIZE_HALF) && ofs[0])
      err = 1'b1;
    else if ((size == HSIZE_WORD) && (ofs != 2'b00))
      err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/dram_arbiter_port.sv
// One AHB-lite slave port of the DRAM arbiter: one-entry address-phase
// capture, alignment/size check, two-cycle ERROR response and hready/hresp.
module dram_arbiter_port
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       haddr_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [1:0]        htrans_i,
  input  logic              hmastlock_i,
  input  logic              grant_i,
  output logic              req_o,
  output logic [ADDR_W+1:0] addr_o,
  output logic              write_o,
  output logic [2:0]        size_o,
  output logic              lock_o,
  output logic              hready_o,
  output logic              hresp_o
);

  logic              pend_v_q,    pend_v_d;
  logic [ADDR_W+1:0] pend_addr_q, pend_addr_d;
  logic              pend_wr_q,   pend_wr_d;
  logic [2:0]        pend_size_q, pend_size_d;
  logic              pend_lock_q, pend_lock_d;
  logic              pend_err_q,  pend_err_d;
  logic              err2_q,      err2_d;

  logic capture;
  logic unused_haddr;

  // Only the RAM-reachable address bits are kept.
  assign unused_haddr = ^haddr_i[31:ADDR_W+2];

  assign capture = hready_o & ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));

  // Next-state for the pending entry; an error entry lives for exactly one
  // cycle (first ERROR cycle) and hands over to err2 for the second.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_wr_d   = pend_wr_q;
    pend_size_d = pend_size_q;
    pend_lock_d = pend_lock_q;
    pend_err_d  = pend_err_q;
    err2_d      = pend_v_q & pend_err_q;
    if (capture) begin
      pend_v_d    = 1'b1;
      pend_addr_d = haddr_i[ADDR_W+1:0];
      pend_wr_d   = hwrite_i;
      pend_size_d = hsize_i;
      pend_lock_d = hmastlock_i;
      pend_err_d  = size_err_f(hsize_i, haddr_i[1:0]);
    end else if (pend_v_q && (pend_err_q || grant_i)) begin
      pend_v_d = 1'b0;
    end
  end

  // Pending entry and error sequencer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_wr_q   <= 1'b0;
      pend_size_q <= 3'd0;
      pend_lock_q <= 1'b0;
      pend_err_q  <= 1'b0;
      err2_q      <= 1'b0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_wr_q   <= pend_wr_d;
      pend_size_q <= pend_size_d;
      pend_lock_q <= pend_lock_d;
      pend_err_q  <= pend_err_d;
      err2_q      <= err2_d;
    end
  end

  assign req_o    = pend_v_q & ~pend_err_q;
  assign addr_o   = pend_addr_q;
  assign write_o  = pend_wr_q;
  assign size_o   = pend_size_q;
  assign lock_o   = pend_lock_q;
  assign hready_o = ~pend_v_q;
  assign hresp_o  = ((pend_v_q & pend_err_q) | err2_q) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/dram_arbiter.sv
// Two-master AHB-lite arbiter sharing the byte-lane data RAM between the
// core data port (dmem) and the SPI loader (spi).
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int   ADDR_W    = 14,
  parameter logic SPI_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       dmem_haddr,
  input  logic              dmem_hwrite,
  input  logic [2:0]        dmem_hsize,
  input  logic [1:0]        dmem_htrans,
  input  logic              dmem_hmastlock,
  input  logic [31:0]       dmem_hwdata,
  output logic [31:0]       dmem_hrdata,
  output logic              dmem_hready,
  output logic              dmem_hresp,
  input  logic [31:0]       spi_haddr,
  input  logic              spi_hwrite,
  input  logic [2:0]        spi_hsize,
  input  logic [1:0]        spi_htrans,
  input  logic              spi_hmastlock,
  input  logic [31:0]       spi_hwdata,
  output logic [31:0]       spi_hrdata,
  output logic              spi_hready,
  output logic              spi_hresp,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rwn,
  output logic [3:0]        ram_wben,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic              d_req,  s_req;
  logic [ADDR_W+1:0] d_addr, s_addr;
  logic              d_wr,   s_wr;
  logic [2:0]        d_size, s_size;
  logic              d_lock, s_lock;

  logic              gnt_d, gnt_s, any_gnt, tie;
  logic [ADDR_W+1:0] win_addr;
  logic              win_wr;
  logic [2:0]        win_size;
  logic              win_lock;
  logic [31:0]       win_wdata;

  logic              lock_v_q,    lock_v_d;
  logic              lock_spi_q,  lock_spi_d;
  logic              rr_spi_q,    rr_spi_d;
  logic              rd_dmem_q,   rd_dmem_d;
  logic              rd_spi_q,    rd_spi_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  dram_arbiter_port #(.ADDR_W(ADDR_W)) u_dmem_port (
    .clk_i       (clk),
    .rst_n_i     (reset),
    .haddr_i     (dmem_haddr),
    .hwrite_i    (dmem_hwrite),
    .hsize_i     (dmem_hsize),
    .htrans_i    (dmem_htrans),
    .hmastlock_i (dmem_hmastlock),
    .grant_i     (gnt_d),
    .req_o       (d_req),
    .addr_o      (d_addr),
    .write_o     (d_wr),
    .size_o      (d_size),
    .lock_o      (d_lock),
    .hready_o    (dmem_hready),
    .hresp_o     (dmem_hresp)
  );

  dram_arbiter_port #(.ADDR_W(ADDR_W)) u_spi_port (
    .clk_i       (clk),
    .rst_n_i     (reset),
    .haddr_i     (spi_haddr),
    .hwrite_i    (spi_hwrite),
    .hsize_i     (spi_hsize),
    .htrans_i    (spi_htrans),
    .hmastlock_i (spi_hmastlock),
    .grant_i     (gnt_s),
    .req_o       (s_req),
    .addr_o      (s_addr),
    .write_o     (s_wr),
    .size_o      (s_size),
    .lock_o      (s_lock),
    .hready_o    (spi_hready),
    .hresp_o     (spi_hresp)
  );

  // Arbitration. A held lock reserves the RAM for its owner even in the
  // owner's gap cycles, otherwise the other master would slip in between
  // locked beats. The round-robin pointer moves only when a tie is decided.
  always_comb begin
    gnt_d = 1'b0;
    gnt_s = 1'b0;
    tie   = 1'b0;
    if (reset) begin
      if (lock_v_q) begin
        if (lock_spi_q) gnt_s = s_req;
        else            gnt_d = d_req;
      end else if (d_req && s_req) begin
        tie = 1'b1;
        if (rr_spi_q) gnt_s = 1'b1;
        else          gnt_d = 1'b1;
      end else begin
        gnt_d = d_req;
        gnt_s = s_req;
      end
    end
  end

  assign any_gnt = gnt_d | gnt_s;

  // Winner's entry and write data.
  always_comb begin
    win_addr  = gnt_s ? s_addr      : d_addr;
    win_wr    = gnt_s ? s_wr        : d_wr;
    win_size  = gnt_s ? s_size      : d_size;
    win_lock  = gnt_s ? s_lock      : d_lock;
    win_wdata = gnt_s ? spi_hwdata  : dmem_hwdata;
  end

  // Next-state for lock owner, tie pointer, read owner and held RAM bus.
  always_comb begin
    lock_v_d    = lock_v_q;
    lock_spi_d  = lock_spi_q;
    rr_spi_d    = rr_spi_q;
    rd_dmem_d   = gnt_d & ~d_wr;
    rd_spi_d    = gnt_s & ~s_wr;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (tie)
      rr_spi_d = gnt_d;
    if (any_gnt) begin
      ram_addr_d  = win_addr[ADDR_W+1:2];
      ram_wdata_d = win_wdata;
      if (win_lock) begin
        lock_v_d   = 1'b1;
        lock_spi_d = gnt_s;
      end else if (lock_v_q && (lock_spi_q == gnt_s)) begin
        lock_v_d = 1'b0;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_v_q    <= 1'b0;
      lock_spi_q  <= 1'b0;
      rr_spi_q    <= SPI_FIRST;
      rd_dmem_q   <= 1'b0;
      rd_spi_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      lock_v_q    <= lock_v_d;
      lock_spi_q  <= lock_spi_d;
      rr_spi_q    <= rr_spi_d;
      rd_dmem_q   <= rd_dmem_d;
      rd_spi_q    <= rd_spi_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_addr    = any_gnt ? win_addr[ADDR_W+1:2] : ram_addr_q;
  assign ram_wdata   = any_gnt ? win_wdata : ram_wdata_q;
  assign ram_rwn     = ~(any_gnt & win_wr);
  assign ram_wben    = (any_gnt && win_wr) ? wben_f(win_size, win_addr[1:0]) : 4'b0000;

  assign dmem_hrdata = rd_dmem_q ? ram_rdata : 32'h0;
  assign spi_hrdata  = rd_spi_q  ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter with a byte-lane RAM model.
module tb_dram_arbiter;
  import dram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dmem_haddr, spi_haddr;
  logic        dmem_hwrite, spi_hwrite;
  logic [2:0]  dmem_hsize, spi_hsize;
  logic [1:0]  dmem_htrans, spi_htrans;
  logic        dmem_hmastlock, spi_hmastlock;
  logic [31:0] dmem_hwdata, spi_hwdata;
  logic [31:0] dmem_hrdata, spi_hrdata;
  logic        dmem_hready, spi_hready;
  logic        dmem_hresp, spi_hresp;
  logic [13:0] ram_addr;
  logic        ram_rwn;
  logic [3:0]  ram_wben;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int saved_wr;

  logic [31:0] mem [0:16383];

  dram_arbiter #(.ADDR_W(14), .SPI_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hsize(dmem_hsize),
    .dmem_htrans(dmem_htrans), .dmem_hmastlock(dmem_hmastlock), .dmem_hwdata(dmem_hwdata),
    .dmem_hrdata(dmem_hrdata), .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
    .spi_haddr(spi_haddr), .spi_hwrite(spi_hwrite), .spi_hsize(spi_hsize),
    .spi_htrans(spi_htrans), .spi_hmastlock(spi_hmastlock), .spi_hwdata(spi_hwdata),
    .spi_hrdata(spi_hrdata), .spi_hready(spi_hready), .spi_hresp(spi_hresp),
    .ram_addr(ram_addr), .ram_rwn(ram_rwn), .ram_wben(ram_wben),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wben[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
    if (ram_wben != 4'b0000) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic dmem_req(input logic [31:0] a, input logic w, input logic [2:0] s, input logic lk);
    dmem_haddr = a; dmem_hwrite = w; dmem_hsize = s; dmem_htrans = HTRANS_NONSEQ; dmem_hmastlock = lk;
  endtask

  task automatic dmem_idle;
    dmem_htrans = HTRANS_IDLE; dmem_hmastlock = 1'b0;
  endtask

  task automatic spi_req(input logic [31:0] a, input logic w, input logic [2:0] s, input logic lk);
    spi_haddr = a; spi_hwrite = w; spi_hsize = s; spi_htrans = HTRANS_NONSEQ; spi_hmastlock = lk;
  endtask

  task automatic spi_idle;
    spi_htrans = HTRANS_IDLE; spi_hmastlock = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick; tick;
    reset = 1'b1;
    #2;
    n_cmp++; if (dmem_hready !== 1'b1) begin n_bad++; $display("FAIL rst_dmem_hready: got %b want 1", dmem_hready); end
    n_cmp++; if (spi_hready !== 1'b1) begin n_bad++; $display("FAIL rst_spi_hready: got %b want 1", spi_hready); end
    n_cmp++; if ({dmem_hresp, spi_hresp} !== 2'b00) begin n_bad++; $display("FAIL rst_hresp: got %b%b want 00", dmem_hresp, spi_hresp); end
    n_cmp++; if (dmem_hrdata !== 32'h0) begin n_bad++; $display("FAIL rst_dmem_hrdata: got %h want 0", dmem_hrdata); end
    n_cmp++; if (spi_hrdata !== 32'h0) begin n_bad++; $display("FAIL rst_spi_hrdata: got %h want 0", spi_hrdata); end
    n_cmp++; if (ram_rwn !== 1'b1) begin n_bad++; $display("FAIL rst_rwn: got %b want 1", ram_rwn); end
    n_cmp++; if (ram_wben !== 4'b0000) begin n_bad++; $display("FAIL rst_wben: got %b want 0000", ram_wben); end
    n_cmp++; if (ram_addr !== 14'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", ram_addr); end
    n_cmp++; if (ram_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", ram_wdata); end
    // BUSY transfer must be ignored
    dmem_haddr = 32'h10; dmem_hwrite = 1'b1; dmem_hsize = HSIZE_WORD; dmem_htrans = HTRANS_BUSY;
    tick;
    #2;
    n_cmp++; if (dmem_hready !== 1'b1) begin n_bad++; $display("FAIL busy_ignored_hready: got %b want 1", dmem_hready); end
    n_cmp++; if (ram_wben !== 4'b0000) begin n_bad++; $display("FAIL busy_ignored_wben: got %b want 0000", ram_wben); end
    dmem_idle;
  endtask

  task automatic test_dmem_word;
    dmem_req(32'h10, 1'b1, HSIZE_WORD, 1'b0);
    tick;
    dmem_idle; dmem_hwdata = 32'hDEADBEEF;
    #2;
    n_cmp++; if (ram_rwn !== 1'b0) begin n_bad++; $display("FAIL wr_rwn: got %b want 0", ram_rwn); end
    n_cmp++; if (ram_wben !== 4'b1111) begin n_bad++; $display("FAIL wr_wben: got %b want 1111", ram_wben); end
    n_cmp++; if (ram_addr !== 14'd4) begin n_bad++; $display("FAIL wr_addr: got %h want 4", ram_addr); end
    n_cmp++; if (ram_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_wdata: got %h want deadbeef", ram_wdata); end
    n_cmp++; if (dmem_hready !== 1'b0) begin n_bad++; $display("FAIL wr_wait_hready: got %b want 0", dmem_hready); end
    tick;
    #2;
    n_cmp++; if (dmem_hready !== 1'b1) begin n_bad++; $display("FAIL wr_done_hready: got %b want 1", dmem_hready); end
    n_cmp++; if (ram_wben !== 4'b0000) begin n_bad++; $display("FAIL idle_wben: got %b want 0000", ram_wben); end
    n_cmp++; if (ram_addr !== 14'd4) begin n_bad++; $display("FAIL idle_addr_hold: got %h want 4", ram_addr); end
    dmem_req(32'h10, 1'b0, HSIZE_WORD, 1'b0);
    tick;
    dmem_idle;
    #2;
    n_cmp++; if ({ram_rwn, ram_wben} !== 5'b10000) begin n_bad++; $display("FAIL rd_rwn_wben: got %b/%b want 1/0000", ram_rwn, ram_wben); end
    n_cmp++; if (ram_addr !== 14'd4) begin n_bad++; $display("FAIL rd_addr: got %h want 4", ram_addr); end
    tick;
    #2;
    n_cmp++; if (dmem_hready !== 1'b1) begin n_bad++; $display("FAIL rd_hready: got %b want 1", dmem_hready); end
    n_cmp++; if (dmem_hrdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", dmem_hrdata); end
  endtask

  task automatic test_spi_byte_half;
    spi_req(32'h13, 1'b1, HSIZE_BYTE, 1'b0);
    tick;
    spi_idle; spi_hwdata = 32'hAA000000;
    #2;
    n_cmp++; if (ram_wben !== 4'b1000) begin n_bad++; $display("FAIL byte_wben: got %b want 1000", ram_wben); end
    n_cmp++; if (ram_wdata[31:24] !== 8'hAA) begin n_bad++; $display("FAIL byte_wdata: got %h want aa", ram_wdata[31:24]); end
    tick;
    #2;
    n_cmp++; if (spi_hready !== 1'b1) begin n_bad++; $display("FAIL byte_done_hready: got %b want 1", spi_hready); end
    spi_req(32'h12, 1'b1, HSIZE_HALF, 1'b0);
    tick;
    spi_idle; spi_hwdata = 32'hBBCC0000;
    #2;
    n_cmp++; if (ram_wben !== 4'b1100) begin n_bad++; $display("FAIL half_wben: got %b want 1100", ram_wben); end
    tick;
    dmem_req(32'h10, 1'b0, HSIZE_WORD, 1'b0);
    tick;
    dmem_idle;
    tick;
    #2;
    n_cmp++; if (dmem_hrdata !== 32'hBBCCBEEF) begin n_bad++; $display("FAIL merge_rd_data: got %h want bbccbeef", dmem_hrdata); end
    n_cmp++; if (spi_hrdata !== 32'h0) begin n_bad++; $display("FAIL other_hrdata: got %h want 0", spi_hrdata); end
  endtask

  task automatic test_tie;
    tick;
    dmem_req(32'h20, 1'b1, HSIZE_WORD, 1'b0);
    spi_req(32'h24, 1'b1, HSIZE_WORD, 1'b0);
    tick;
    dmem_idle; spi_idle; dmem_hwdata = 32'h11111111; spi_hwdata = 32'h22222222;
    #2;
    n_cmp++; if (ram_addr !== 14'd9) begin n_bad++; $display("FAIL tie1_addr: got %h want 9", ram_addr); end
    n_cmp++; if (ram_wdata !== 32'h22222222) begin n_bad++; $display("FAIL tie1_wdata: got %h want 22222222", ram_wdata); end
    n_cmp++; if ({dmem_hready, spi_hready} !== 2'b00) begin n_bad++; $display("FAIL tie1_hready: got %b%b want 00", dmem_hready, spi_hready); end
    tick;
    #2;
    n_cmp++; if (ram_addr !== 14'd8) begin n_bad++; $display("FAIL tie1_second_addr: got %h want 8", ram_addr); end
    n_cmp++; if (ram_wdata !== 32'h11111111) begin n_bad++; $display("FAIL tie1_second_wdata: got %h want 11111111", ram_wdata); end
    n_cmp++; if ({dmem_hready, spi_hready} !== 2'b01) begin n_bad++; $display("FAIL tie1_second_hready: got %b%b want 01", dmem_hready, spi_hready); end
    tick;
    #2;
    n_cmp++; if (dmem_hready !== 1'b1) begin n_bad++; $display("FAIL tie1_dmem_done: got %b want 1", dmem_hready); end
    dmem_req(32'h28, 1'b1, HSIZE_WORD, 1'b0);
    spi_req(32'h2C, 1'b1, HSIZE_WORD, 1'b0);
    tick;
    dmem_idle; spi_idle; dmem_hwdata = 32'h33333333; spi_hwdata = 32'h44444444;
    #2;
    n_cmp++; if (ram_addr !== 14'd10) begin n_bad++; $display("FAIL tie2_addr: got %h want a", ram_addr); end
    n_cmp++; if (ram_wdata !== 32'h33333333) begin n_bad++; $display("FAIL tie2_wdata: got %h want 33333333", ram_wdata); end
    tick;
    #2;
    n_cmp++; if (ram_addr !== 14'd11) begin n_bad++; $display("FAIL tie2_second_addr: got %h want b", ram_addr); end
    tick;
  endtask

  task automatic test_lock;
    dmem_req(32'h30, 1'b1, HSIZE_WORD, 1'b1);
    tick;
    dmem_idle; dmem_hwdata = 32'hA1A1A1A1;
    spi_req(32'h40, 1'b1, HSIZE_WORD, 1'b0);
    #2;
    n_cmp++; if (ram_addr !== 14'd12) begin n_bad++; $display("FAIL lock_w1_addr: got %h want c", ram_addr); end
    tick;
    spi_idle; spi_hwdata = 32'hB0B0B0B0;
    dmem_req(32'h34, 1'b1, HSIZE_WORD, 1'b1);
    #2;
    n_cmp++; if (spi_hready !== 1'b0) begin n_bad++; $display("FAIL lock_gap1_spi_hready: got %b want 0", spi_hready); end
    n_cmp++; if (ram_wben !== 4'b0000) begin n_bad++; $display("FAIL lock_gap1_wben: got %b want 0000", ram_wben); end
    tick;
    dmem_idle; dmem_hwdata = 32'hA2A2A2A2;
    #2;
    n_cmp++; if (ram_addr !== 14'd13) begin n_bad++; $display("FAIL lock_w2_addr: got %h want d", ram_addr); end
    tick;
    dmem_req(32'h38, 1'b1, HSIZE_WORD, 1'b1);
    #2;
    n_cmp++; if (ram_wben !== 4'b0000) begin n_bad++; $display("FAIL lock_gap2_wben: got %b want 0000", ram_wben); end
    tick;
    dmem_idle; dmem_hwdata = 32'hA3A3A3A3;
    #2;
    n_cmp++; if (ram_addr !== 14'd14) begin n_bad++; $display("FAIL lock_w3_addr: got %h want e", ram_addr); end
    tick;
    dmem_req(32'h3C, 1'b1, HSIZE_WORD, 1'b0);
    #2;
    n_cmp++; if ({spi_hready, ram_wben} !== 5'b00000) begin n_bad++; $display("FAIL lock_gap3: got %b/%b want 0/0000", spi_hready, ram_wben); end
    tick;
    dmem_idle; dmem_hwdata = 32'hA4A4A4A4;
    #2;
    n_cmp++; if (ram_addr !== 14'd15) begin n_bad++; $display("FAIL lock_w4_addr: got %h want f", ram_addr); end
    n_cmp++; if (spi_hready !== 1'b0) begin n_bad++; $display("FAIL lock_w4_spi_hready: got %b want 0", spi_hready); end
    tick;
    #2;
    n_cmp++; if (ram_addr !== 14'd16) begin n_bad++; $display("FAIL lock_spi_addr: got %h want 10", ram_addr); end
    n_cmp++; if (ram_wdata !== 32'hB0B0B0B0) begin n_bad++; $display("FAIL lock_spi_wdata: got %h want b0b0b0b0", ram_wdata); end
    tick;
    #2;
    n_cmp++; if (spi_hready !== 1'b1) begin n_bad++; $display("FAIL lock_spi_done: got %b want 1", spi_hready); end
  endtask

  task automatic test_error;
    saved_wr = wr_cnt;
    dmem_req(32'h02, 1'b1, HSIZE_WORD, 1'b0);
    spi_req(32'h05, 1'b0, HSIZE_HALF, 1'b0);
    tick;
    dmem_idle; spi_idle;
    #2;
    n_cmp++; if ({dmem_hready, dmem_hresp} !== 2'b01) begin n_bad++; $display("FAIL err1_dmem: got rdy %b resp %b want 0 1", dmem_hready, dmem_hresp); end
    n_cmp++; if ({spi_hready, spi_hresp} !== 2'b01) begin n_bad++; $display("FAIL err1_spi: got rdy %b resp %b want 0 1", spi_hready, spi_hresp); end
    n_cmp++; if (ram_wben !== 4'b0000) begin n_bad++; $display("FAIL err1_wben: got %b want 0000", ram_wben); end
    tick;
    #2;
    n_cmp++; if ({dmem_hready, dmem_hresp} !== 2'b11) begin n_bad++; $display("FAIL err2_dmem: got rdy %b resp %b want 1 1", dmem_hready, dmem_hresp); end
    n_cmp++; if (ram_wben !== 4'b0000) begin n_bad++; $display("FAIL err2_wben: got %b want 0000", ram_wben); end
    tick;
    #2;
    n_cmp++; if ({dmem_hresp, spi_hresp} !== 2'b00) begin n_bad++; $display("FAIL err_end_hresp: got %b%b want 00", dmem_hresp, spi_hresp); end
    n_cmp++; if (wr_cnt !== saved_wr) begin n_bad++; $display("FAIL err_no_ram_write: got %0d want %0d", wr_cnt, saved_wr); end
    spi_req(32'h08, 1'b1, 3'd3, 1'b0);
    tick;
    spi_idle;
    #2;
    n_cmp++; if ({spi_hresp, ram_wben} !== 5'b10000) begin n_bad++; $display("FAIL err_size_spi: got %b/%b want 1/0000", spi_hresp, ram_wben); end
    tick; tick;
  endtask

  task automatic test_reset_mid;
    spi_req(32'h44, 1'b1, HSIZE_WORD, 1'b0);
    tick;
    spi_idle; spi_hwdata = 32'h55555555;
    reset = 1'b0;
    saved_wr = wr_cnt;
    #2;
    n_cmp++; if (ram_wben !== 4'b0000) begin n_bad++; $display("FAIL rstmid_wben: got %b want 0000", ram_wben); end
    tick;
    reset = 1'b1;
    #2;
    n_cmp++; if ({dmem_hready, spi_hready} !== 2'b11) begin n_bad++; $display("FAIL rstmid_hready: got %b%b want 11", dmem_hready, spi_hready); end
    n_cmp++; if (ram_wben !== 4'b0000) begin n_bad++; $display("FAIL rstmid_after_wben: got %b want 0000", ram_wben); end
    tick;
    #2;
    n_cmp++; if (wr_cnt !== saved_wr) begin n_bad++; $display("FAIL rstmid_no_write: got %0d want %0d", wr_cnt, saved_wr); end
    n_cmp++; if (mem[17] !== 32'h0) begin n_bad++; $display("FAIL rstmid_mem: got %h want 0", mem[17]); end
  endtask

  initial begin
    reset = 1'b0;
    dmem_haddr = '0; dmem_hwrite = 1'b0; dmem_hsize = HSIZE_WORD; dmem_htrans = HTRANS_IDLE;
    dmem_hmastlock = 1'b0; dmem_hwdata = '0;
    spi_haddr = '0; spi_hwrite = 1'b0; spi_hsize = HSIZE_WORD; spi_htrans = HTRANS_IDLE;
    spi_hmastlock = 1'b0; spi_hwdata = '0;
    test_reset;
    test_dmem_word;
    test_spi_byte_half;
    test_tie;
    test_lock;
    test_error;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
